// File: rtl/load_store_unit.sv
// Memory-stage front end for a 32-bit data BRAM: RV32I loads/stores, lane alignment and load extension.
// Optional build macro LSU_MISALIGN_CHECK_EN enables misaligned-access detection.
module load_store_unit #(
  parameter int ADDR_W = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic [31:0] bram_pc,
  output logic [3:0]  bram_w_enable,
  output logic [31:0] bram_r_addr,
  output logic [31:0] bram_w_addr,
  output logic [31:0] bram_w_data,
  output logic [31:0] bram_row_addr,
  input  logic [31:0] bram_r_data,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken when req_valid && req_ready; a response is
  // retired when resp_valid && resp_ready. Response outputs hold until retired.
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept, legal, misaligned, fault;
  logic [1:0]  off, eff_off, ld_off;
  logic [2:0]  ld_funct3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign off           = req_addr[1:0];
  assign accept        = req_valid && req_ready;
  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign state_dbg     = state;
  assign bram_pc       = req_pc;
  assign bram_row_addr = req_addr;
  assign bram_r_addr   = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
  assign bram_w_addr   = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = legal && (((req_funct3[1:0] == 2'b01) && off[0]) ||
                                ((req_funct3[1:0] == 2'b10) && (off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign fault = !legal || misaligned;

  // Halves and words snap to their containing aligned unit.
  always_comb begin
    eff_off = off;
    case (req_funct3[1:0])
      2'b00:   eff_off = off;
      2'b01:   eff_off = {off[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

  always_comb begin
    bram_w_enable = 4'b0000;
    if (accept && req_we && !fault && !rst) begin
      case (req_funct3[1:0])
        2'b00:   bram_w_enable = 4'b0001 << eff_off;
        2'b01:   bram_w_enable = eff_off[1] ? 4'b1100 : 4'b0011;
        default: bram_w_enable = 4'b1111;
      endcase
    end
  end

  always_comb begin
    bram_w_data = req_wdata;
    case (req_funct3[1:0])
      2'b00:   bram_w_data = {4{req_wdata[7:0]}};
      2'b01:   bram_w_data = {2{req_wdata[15:0]}};
      default: bram_w_data = req_wdata;
    endcase
  end

  always_comb begin
    ld_byte = bram_r_data[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? bram_r_data[31:16] : bram_r_data[15:0];
    case (ld_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bram_r_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = (req_we || fault) ? RESP : LOAD_WAIT;
      LOAD_WAIT: state_nxt = RESP;
      RESP:      if (resp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data       <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      ld_funct3       <= 3'b000;
      ld_off          <= 2'b00;
    end else if (accept) begin
      resp_data       <= 32'h0;
      resp_misaligned <= misaligned;
      resp_illegal    <= !legal;
      ld_funct3       <= req_funct3;
      ld_off          <= eff_off;
    end else if (state == LOAD_WAIT) begin
      resp_data <= ld_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset sequence, randomized ops vs a byte-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_misaligned, resp_illegal;
  logic [31:0] bram_pc, bram_r_addr, bram_w_addr, bram_w_data, bram_row_addr, bram_r_data;
  logic [3:0]  bram_w_enable;
  logic [1:0]  state_dbg;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.ADDR_W(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .bram_pc(bram_pc), .bram_w_enable(bram_w_enable), .bram_r_addr(bram_r_addr),
    .bram_w_addr(bram_w_addr), .bram_w_data(bram_w_data), .bram_row_addr(bram_row_addr),
    .bram_r_data(bram_r_data), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // BRAM behavioural model: byte-enable write, one-cycle registered read.
  logic [31:0] bram_mem [0:32767];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w = old;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    if (bram_w_enable != 4'b0000)
      bram_mem[bram_w_addr[14:0]] <= merge(bram_mem[bram_w_addr[14:0]], bram_w_data, bram_w_enable);
    bram_r_data <= bram_mem[bram_r_addr[14:0]];
  end

  // Reference model: flat byte-addressed memory over the 17-bit wrapped byte space.
  logic [7:0] ref_mem [0:131071];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [3:0] m_we, output logic [31:0] m_wd, output logic [31:0] m_data,
                       output logic m_mis, output logic m_ill, output int m_lat);
    int size, a, base;
    logic legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    a     = int'(addr & 32'h1FFFF);
`ifdef LSU_MISALIGN_CHECK_EN
    m_mis = legal && ((a % size) != 0);
    base  = a;
`else
    m_mis = 1'b0;
    base  = a - (a % size);
`endif
    m_ill  = !legal;
    m_we   = 4'b0000;
    m_wd   = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
    m_data = 32'h0;
    m_lat  = 1;
    if (legal && !m_mis) begin
      if (we) begin
        for (int i = 0; i < size; i++) begin
          m_we[(base + i) % 4] = 1'b1;
          ref_mem[base + i]    = wdata[8*i +: 8];
        end
      end else begin
        m_lat = 2;
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[base + i];
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        m_data = v;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid  = 1'b0;
    req_we     = 1'(($urandom));
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_pc     = $urandom;
  endtask

  // One request from accept to retirement, with optional consumer stall.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input logic [3:0] e_we, input logic [31:0] e_wd,
                        input logic [31:0] e_data, input logic e_mis, input logic e_ill, input int e_lat);
    int cycles;
    logic [31:0] pc, exp_d;
    pc = $urandom;
    exp_q.push_back(e_data);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_pc = pc;
    #1;
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    check("w_enable", {28'h0, bram_w_enable}, {28'h0, e_we});
    if (e_we != 4'b0000) check("w_data", bram_w_data, e_wd);
    check("w_addr", bram_w_addr, (addr >> 2) & 32'h7FFF);
    check("r_addr", bram_r_addr, (addr >> 2) & 32'h7FFF);
    check("pc_row", {bram_pc ^ pc} | {bram_row_addr ^ addr}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    cycles = 1;
    while (!resp_valid && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", cycles, e_lat);
    exp_d = exp_q.pop_front();
    check("resp_data", resp_data, exp_d);
    check("resp_flags", {30'h0, resp_misaligned, resp_illegal}, {30'h0, e_mis, e_ill});
    for (int k = 0; k < stall; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      @(negedge clk);
      #1;
      check("stall_hold", {resp_valid, req_ready, resp_misaligned, resp_illegal, bram_w_enable, 24'h0} ^ {30'h0, 2'b00} | 32'h0,
            {1'b1, 1'b0, e_mis, e_ill, 4'b0000, 24'h0});
      check("stall_data", resp_data, exp_d);
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("retire", {30'h0, resp_valid, req_ready}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    logic [31:0] e_data;
    logic        e_mis;
    logic        e_ill;
    int          e_lat;
  } vec_t;

  vec_t vec [16];

  initial begin
    logic [3:0]  m_we;
    logic [31:0] m_wd, m_data, wd, ad;
    logic        m_mis, m_ill, we;
    logic [2:0]  f3;
    int          m_lat;

    for (int i = 0; i < 32768; i++) bram_mem[i] = 32'h0;
    for (int i = 0; i < 131072; i++) ref_mem[i] = 8'h0;
    bram_mem[32'h100] = 32'h8899AABB;
    ref_mem[32'h400] = 8'hBB; ref_mem[32'h401] = 8'hAA; ref_mem[32'h402] = 8'h99; ref_mem[32'h403] = 8'h88;
    bram_r_data = 32'h0;

    rst = 1'b1; resp_ready = 1'b0;
    drive_idle();
    #1;
    check("rst_outputs", {28'h0, resp_valid, req_ready, resp_misaligned, resp_illegal}, 32'h4);
    check("rst_data", resp_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    vec[0]  = '{1'b0, 3'b000, 32'h403, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFFF88, 1'b0, 1'b0, 2};
    vec[1]  = '{1'b0, 3'b100, 32'h403, 32'h0, 0, 4'b0000, 32'h0, 32'h00000088, 1'b0, 1'b0, 2};
    vec[2]  = '{1'b0, 3'b001, 32'h402, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFF8899, 1'b0, 1'b0, 2};
    vec[3]  = '{1'b0, 3'b101, 32'h400, 32'h0, 0, 4'b0000, 32'h0, 32'h0000AABB, 1'b0, 1'b0, 2};
`ifdef LSU_MISALIGN_CHECK_EN
    vec[4]  = '{1'b0, 3'b010, 32'h402, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1};
`else
    vec[4]  = '{1'b0, 3'b010, 32'h402, 32'h0, 0, 4'b0000, 32'h0, 32'h8899AABB, 1'b0, 1'b0, 2};
`endif
    vec[5]  = '{1'b1, 3'b000, 32'h402, 32'h000000CD, 0, 4'b0100, 32'hCDCDCDCD, 32'h0, 1'b0, 1'b0, 1};
    vec[6]  = '{1'b0, 3'b010, 32'h400, 32'h0, 0, 4'b0000, 32'h0, 32'h88CDAABB, 1'b0, 1'b0, 2};
    vec[7]  = '{1'b1, 3'b010, 32'h400, 32'h12345678, 0, 4'b1111, 32'h12345678, 32'h0, 1'b0, 1'b0, 1};
    vec[8]  = '{1'b0, 3'b010, 32'h400, 32'h0, 1, 4'b0000, 32'h0, 32'h12345678, 1'b0, 1'b0, 2};
    vec[9]  = '{1'b1, 3'b011, 32'h400, 32'hFFFFFFFF, 3, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1};
    vec[10] = '{1'b1, 3'b011, 32'h401, 32'hFFFFFFFF, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1};
    vec[11] = '{1'b0, 3'b110, 32'h400, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1};
    vec[12] = '{1'b1, 3'b001, 32'h406, 32'hABCD1234, 0, 4'b1100, 32'h12341234, 32'h0, 1'b0, 1'b0, 1};
    vec[13] = '{1'b0, 3'b001, 32'h406, 32'h0, 0, 4'b0000, 32'h0, 32'h00001234, 1'b0, 1'b0, 2};
`ifdef LSU_MISALIGN_CHECK_EN
    vec[14] = '{1'b1, 3'b001, 32'h401, 32'h00005555, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1};
    vec[15] = '{1'b0, 3'b010, 32'h400, 32'h0, 0, 4'b0000, 32'h0, 32'h12345678, 1'b0, 1'b0, 2};
`else
    vec[14] = '{1'b1, 3'b001, 32'h401, 32'h00005555, 0, 4'b0011, 32'h55555555, 32'h0, 1'b0, 1'b0, 1};
    vec[15] = '{1'b0, 3'b010, 32'h400, 32'h0, 0, 4'b0000, 32'h0, 32'h12345555, 1'b0, 1'b0, 2};
`endif

    foreach (vec[i]) begin
      model(vec[i].we, vec[i].f3, vec[i].addr, vec[i].wdata, m_we, m_wd, m_data, m_mis, m_ill, m_lat);
      run_op(vec[i].we, vec[i].f3, vec[i].addr, vec[i].wdata, vec[i].stall,
             vec[i].e_we, vec[i].e_wd, vec[i].e_data, vec[i].e_mis, vec[i].e_ill, vec[i].e_lat);
    end

    // Reset while a load is in LOAD_WAIT, with a store offered during reset.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'hDEADBEEF;
    #1;
    check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mid_w_enable", {28'h0, bram_w_enable}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    model(1'b0, 3'b010, 32'h400, 32'h0, m_we, m_wd, m_data, m_mis, m_ill, m_lat);
    run_op(1'b0, 3'b010, 32'h400, 32'h0, 0, m_we, m_wd, m_data, m_mis, m_ill, m_lat);

    // Randomized ops in a small window, with random upper address bits to exercise wrap.
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      if (!we && f3 == 3'b011) f3 = 3'b100;
      ad = ($urandom & 32'hFFFE0000) | (32'h400 + 32'($urandom_range(0, 31)));
      wd = $urandom;
      model(we, f3, ad, wd, m_we, m_wd, m_data, m_mis, m_ill, m_lat);
      run_op(we, f3, ad, wd, $urandom_range(0, 2), m_we, m_wd, m_data, m_mis, m_ill, m_lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
